// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, default clocking and character constants
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 100_000_000;
    localparam int DEF_BAUD_RATE = 115200;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte request/status handshake between a byte producer and uart_tx
//   master: drives tx_start, byte_to_send; observes tx, busy, end_of_byte
//   slave : the transmitter side
interface uart_tx_if;

    logic       tx_start;
    logic [7:0] byte_to_send;
    logic       tx;
    logic       busy;
    logic       end_of_byte;

    modport master (output tx_start, byte_to_send, input tx, busy, end_of_byte);
    modport slave  (input tx_start, byte_to_send, output tx, busy, end_of_byte);

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: DIV-cycle bit timer with synchronous restart, one-cycle tick per bit
//   clk, reset : system clock, asynchronous active-high reset
//   restart    : zero the count so the next tick lands DIV cycles later
//   tick       : high in the last cycle of each DIV-cycle bit period
module uart_baud_tick #(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == W'(DIV - 1));

    always_comb begin
        cnt_d = (restart || tick) ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit serial transmitter, start + LSB-first data + optional parity + stop
//   clk, reset : system clock, asynchronous active-high reset
//   bus (slave): tx_start/byte_to_send request in; tx line, busy, end_of_byte pulse out
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input logic      clk,
    input logic      reset,
    uart_tx_if.slave bus
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [2:0] bit_q, bit_d;
    logic       tx_q, tx_d;
    logic       restart;
    logic       tick;
    logic       eob;
    logic       parity;

    assign parity = (^data_q) ^ (PARITY_ODD != 0);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // tx_d is the value the line takes in the next bit, so tx stays a clean flop output
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        restart = 1'b0;
        eob     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_start) begin
                    state_d = S_START;
                    data_d  = bus.byte_to_send;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    restart = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    tx_d    = data_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        tx_d    = (PARITY_EN != 0) ? parity : 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_d];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    eob     = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.tx          = tx_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.end_of_byte = eob;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: serial line bit rate.
REQ-003 SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port tx_start  input  1  single-cycle request to send byte_to_send.
REQ-008 SHALL have port byte_to_send  input  8  payload, sampled only on the accepting edge.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port end_of_byte  output  1  one-cycle pulse marking frame completion.

Function
REQ-012 SHALL use DIV = CLK_FREQ/BAUD_RATE (integer, truncated) clock cycles per bit; DIV < 2 SHALL be a static configuration error.
REQ-013 SHALL use states S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, with one-hot encoding.
REQ-014 SHALL accept tx_start only in S_IDLE, latch byte_to_send on that edge, and enter S_START.
REQ-015 SHALL drive tx low and busy high from the cycle after acceptance (1-cycle latency).
REQ-016 SHALL send the start bit (0), then 8 data bits LSB first, then the parity bit if enabled, then 1 stop bit (1); each bit lasts exactly DIV cycles.
REQ-017 SHALL compute parity as XOR of the 8 latched bits, inverted when PARITY_ODD=1.
REQ-018 SHALL use a 3-bit data bit counter: S_DATA to S_PARITY (or to S_STOP) after bit index 7.
REQ-019 SHALL assert end_of_byte in the last cycle of the stop bit, which is cycle 10*DIV (11*DIV with parity) counted from the first start-bit cycle; busy SHALL fall on the following cycle.
REQ-020 SHALL return to S_IDLE the cycle after end_of_byte and be able to accept tx_start in that cycle, supporting an upstream request two cycles after end_of_byte.
REQ-021 SHALL ignore tx_start while busy; the frame in flight and the latched byte SHALL be unaffected.
REQ-022 SHALL restart the baud counter at frame acceptance so that bit timing is independent of idle history.
REQ-023 SHALL register tx; tx SHALL be glitch-free at every bit boundary.
REQ-024 SHALL never pulse end_of_byte outside S_STOP.

Reset
REQ-025 SHALL, on reset, immediately force tx=1, busy=0, end_of_byte=0, state S_IDLE, and all counters and the data latch to 0.
REQ-026 SHALL, on reset mid-frame, abandon the frame without emitting an end_of_byte pulse; the first tx_start after reset release SHALL send a complete frame.

Structure
REQ-027 SHALL take from shared package uart_pkg: the state encodings, the default CLK_FREQ and BAUD_RATE, and the character constants CR 8'h0D, LF 8'h0A, and SPACE 8'h20.
REQ-028 SHALL instantiate one sub-module, uart_baud_tick: a DIV-cycle counter with a synchronous restart that outputs a one-cycle tick at each bit boundary.

Verification
REQ-029 SHALL verify idle after reset: tx=1, busy=0, and end_of_byte=0 for 1000 cycles with no tx_start.
REQ-030 SHALL verify 0x55 at CLK_FREQ=1_000_000, BAUD_RATE=100_000 (DIV=10): tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles; end_of_byte single pulse at cycle 100; busy low at cycle 101.
REQ-031 SHALL verify tx_start with 0xFF injected mid-frame of 0x0D: the line carries only the 0x0D frame, and exactly one end_of_byte pulse occurs.
REQ-032 SHALL verify 0x0D then 0x0A, with the second tx_start two cycles after end_of_byte: two correct frames, with tx high continuously between the stop bit and the second start bit.
REQ-033 SHALL verify reset asserted during data bit 4 of 0x41: tx=1 immediately and no end_of_byte; after release, 0x20 transmits correctly.
REQ-034 SHALL verify PARITY_EN=1, PARITY_ODD=0 with 0x07: parity bit 1, end_of_byte at cycle 11*DIV; with PARITY_ODD=1, parity bit 0.
